// File: rtl/sd_spi_cmd_engine.sv
// SD-card SPI-mode command engine: optional dummy clocks, 48-bit command, R1 poll, extra response bytes.
// Latency: about (INIT_CLKS + 48 + 8*polls + 8*(resp_len-1) + 8) SCLK periods. No backpressure: start is ignored while busy.
// SD_CRC7_GEN_EN selects a serial CRC7 generator instead of the fixed CRC byte table.
module sd_spi_cmd_engine #(
   parameter int CLK_DIV   = 2,
   parameter int INIT_CLKS = 80,
   parameter int NCR_MAX   = 8
) (
   input  logic        input_clk,
   input  logic        resend,
   input  logic        start,
   input  logic        init_req,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   input  logic [2:0]  resp_len,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [7:0]  r1,
   output logic [39:0] response,
   output logic        SCLK,
   output logic        CS_bit,
   output logic        MOSI_bit,
   input  logic        MISO_bit
);

   typedef enum logic [2:0] {S_IDLE, S_INIT, S_SEND, S_POLL, S_READ, S_POST, S_DONE} state_t;

   localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
   localparam logic [15:0] INIT_LAST = 16'(INIT_CLKS - 1);
   localparam logic [7:0]  NCR_LAST  = 8'(NCR_MAX - 1);

   state_t       state_q, state_d;
   logic [15:0]  div_q, div_d;
   logic [15:0]  cnt_q, cnt_d;
   logic [7:0]   byte_q, byte_d;
   logic         sclk_q, sclk_d;
   logic         cs_q, cs_d;
   logic         mosi_q, mosi_d;
   logic [47:0]  tx_q, tx_d;
   logic [7:0]   rx_q, rx_d;
   logic [2:0]   len_q, len_d;
   logic [7:0]   r1_q, r1_d;
   logic [39:0]  resp_q, resp_d;
   logic         tmo_q, tmo_d;
   logic         active, tick, rise, fall;

   function automatic logic [2:0] clamp_len(input logic [2:0] l);
      if (l <= 3'd1) return 3'd1;
      if (l >= 3'd5) return 3'd5;
      return l;
   endfunction

`ifdef SD_CRC7_GEN_EN
   logic [6:0] crc_q, crc_d, crc_nx;
   // CRC byte is patched into tx_q once bit 39 leaves, so it is never needed at start.
   function automatic logic [7:0] start_crc(input logic [5:0] idx);
      return {idx[0], 7'd0} & 8'h00;
   endfunction
`else
   function automatic logic [7:0] start_crc(input logic [5:0] idx);
      case (idx)
         6'd0:    return 8'h95;
         6'd8:    return 8'h87;
         default: return 8'h01;
      endcase
   endfunction
`endif

   always_comb begin
      state_d = state_q;
      div_d   = 16'd0;
      cnt_d   = cnt_q;
      byte_d  = byte_q;
      sclk_d  = sclk_q;
      cs_d    = cs_q;
      mosi_d  = mosi_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      len_d   = len_q;
      r1_d    = r1_q;
      resp_d  = resp_q;
      tmo_d   = tmo_q;
`ifdef SD_CRC7_GEN_EN
      crc_d   = crc_q;
      crc_nx  = {crc_q[5:0], 1'b0} ^ ({7{tx_q[47] ^ crc_q[6]}} & 7'h09);
`endif
      active = (state_q != S_IDLE) && (state_q != S_DONE);
      tick   = (div_q == DIV_LAST);
      rise   = active && tick && !sclk_q;
      fall   = active && tick && sclk_q;
      if (active) div_d = tick ? 16'd0 : div_q + 16'd1;
      if (active && tick) sclk_d = ~sclk_q;
      if (rise) rx_d = {rx_q[6:0], MISO_bit};

      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d  = clamp_len(resp_len);
               tx_d   = {2'b01, cmd_index, cmd_arg, start_crc(cmd_index)};
               resp_d = 40'd0;
               tmo_d  = 1'b0;
               r1_d   = 8'hFF;
               cnt_d  = 16'd0;
               byte_d = 8'd0;
`ifdef SD_CRC7_GEN_EN
               crc_d  = 7'd0;
`endif
               if (init_req) begin
                  state_d = S_INIT;
                  cs_d    = 1'b1;
                  mosi_d  = 1'b1;
               end else begin
                  state_d = S_SEND;
                  cs_d    = 1'b0;
                  mosi_d  = 1'b0;
               end
            end
         end
         S_INIT: begin
            if (fall) begin
               if (cnt_q == INIT_LAST) begin
                  state_d = S_SEND;
                  cnt_d   = 16'd0;
                  cs_d    = 1'b0;
                  mosi_d  = tx_q[47];
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         S_SEND: begin
            if (fall) begin
`ifdef SD_CRC7_GEN_EN
               if (cnt_q < 16'd40) crc_d = crc_nx;
`endif
               if (cnt_q == 16'd47) begin
                  state_d = S_POLL;
                  cnt_d   = 16'd0;
                  byte_d  = 8'd0;
                  mosi_d  = 1'b1;
               end else begin
                  cnt_d  = cnt_q + 16'd1;
                  tx_d   = {tx_q[46:0], 1'b0};
                  mosi_d = tx_q[46];
`ifdef SD_CRC7_GEN_EN
                  if (cnt_q == 16'd39) begin
                     tx_d[47:40] = {crc_nx, 1'b1};
                     mosi_d      = crc_nx[6];
                  end
`endif
               end
            end
         end
         S_POLL: begin
            if (fall) begin
               if (cnt_q == 16'd7) begin
                  cnt_d = 16'd0;
                  if (!rx_q[7]) begin
                     r1_d   = rx_q;
                     resp_d = {32'd0, rx_q};
                     byte_d = 8'd0;
                     if (len_q > 3'd1) begin
                        state_d = S_READ;
                     end else begin
                        state_d = S_POST;
                        cs_d    = 1'b1;
                     end
                  end else if (byte_q == NCR_LAST) begin
                     byte_d  = byte_q + 8'd1;
                     tmo_d   = 1'b1;
                     r1_d    = 8'hFF;
                     state_d = S_POST;
                     cs_d    = 1'b1;
                  end else begin
                     byte_d = byte_q + 8'd1;
                  end
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         S_READ: begin
            if (fall) begin
               if (cnt_q == 16'd7) begin
                  cnt_d  = 16'd0;
                  resp_d = {resp_q[31:0], rx_q};
                  byte_d = byte_q + 8'd1;
                  if ((byte_q + 8'd1) == ({5'd0, len_q} - 8'd1)) begin
                     state_d = S_POST;
                     cs_d    = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         S_POST: begin
            if (fall) begin
               if (cnt_q == 16'd7) begin
                  state_d = S_DONE;
                  cnt_d   = 16'd0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge input_clk or negedge resend) begin
      if (!resend) begin
         state_q <= S_IDLE;
         div_q   <= 16'd0;
         cnt_q   <= 16'd0;
         byte_q  <= 8'd0;
         sclk_q  <= 1'b0;
         cs_q    <= 1'b1;
         mosi_q  <= 1'b1;
         tx_q    <= 48'd0;
         rx_q    <= 8'hFF;
         len_q   <= 3'd1;
         r1_q    <= 8'hFF;
         resp_q  <= 40'd0;
         tmo_q   <= 1'b0;
`ifdef SD_CRC7_GEN_EN
         crc_q   <= 7'd0;
`endif
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         byte_q  <= byte_d;
         sclk_q  <= sclk_d;
         cs_q    <= cs_d;
         mosi_q  <= mosi_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         len_q   <= len_d;
         r1_q    <= r1_d;
         resp_q  <= resp_d;
         tmo_q   <= tmo_d;
`ifdef SD_CRC7_GEN_EN
         crc_q   <= crc_d;
`endif
      end
   end

   assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done     = (state_q == S_DONE);
   assign timeout  = tmo_q;
   assign r1       = r1_q;
   assign response = resp_q;
   assign SCLK     = sclk_q;
   assign CS_bit   = cs_q;
   assign MOSI_bit = mosi_q;

endmodule
